// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, register indices, icodes and the
// writeback control state type.
package y86_pkg;

  typedef enum logic [2:0] {
    SBUB = 3'd0,
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  typedef enum logic {
    WB_RUN,
    WB_HALTED
  } wb_state_e;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] RRAX = 4'h0;
  localparam logic [3:0] RRCX = 4'h1;
  localparam logic [3:0] RRDX = 4'h2;
  localparam logic [3:0] RRBX = 4'h3;
  localparam logic [3:0] RRSP = 4'h4;
  localparam logic [3:0] RRBP = 4'h5;
  localparam logic [3:0] RRSI = 4'h6;
  localparam logic [3:0] RRDI = 4'h7;
  localparam logic [3:0] RR8  = 4'h8;
  localparam logic [3:0] RR9  = 4'h9;
  localparam logic [3:0] RR10 = 4'hA;
  localparam logic [3:0] RR11 = 4'hB;
  localparam logic [3:0] RR12 = 4'hC;
  localparam logic [3:0] RR13 = 4'hD;
  localparam logic [3:0] RR14 = 4'hE;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Undefined status encodings 5..7 are folded into SINS.
  function automatic stat_e normalize_stat(input logic [2:0] s);
    return (s > 3'd4) ? SINS : stat_e'(s);
  endfunction

endpackage

// File: rtl/regfile_2w3r.sv
// Program register storage: two write ports with selectable priority and
// three combinational read ports; indices >= NREG (RNONE) read as zero.
module regfile_2w3r #(
  parameter int NREG   = 15,
  parameter int W      = 64,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_a,
  input  logic [3:0]   waddr_a,
  input  logic [W-1:0] wdata_a,
  input  logic         we_b,
  input  logic [3:0]   waddr_b,
  input  logic [W-1:0] wdata_b,
  input  logic         prio_b,
  input  logic [3:0]   raddr0,
  input  logic [3:0]   raddr1,
  input  logic [3:0]   raddr2,
  output logic [W-1:0] rdata0,
  output logic [W-1:0] rdata1,
  output logic [W-1:0] rdata2
);

  logic [W-1:0]    regs [NREG];
  logic [NREG-1:0] win_a;
  logic [NREG-1:0] win_b;

  // Per-entry winner: when both ports target the same entry, prio_b decides.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREG; i++) begin
      win_b[i] = we_b && (waddr_b == 4'(i)) &&
                 (prio_b || !(we_a && (waddr_a == 4'(i))));
      win_a[i] = we_a && (waddr_a == 4'(i)) && !win_b[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (win_b[i])      regs[i] <= wdata_b;
        else if (win_a[i]) regs[i] <= wdata_a;
      end
    end
  end

  function automatic logic [W-1:0] read_port(input logic [3:0] addr);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == 4'(i)) begin
        v = regs[i];
        if (BYPASS) begin
          if (win_b[i])      v = wdata_b;
          else if (win_a[i]) v = wdata_a;
        end
      end
    end
    return v;
  endfunction

  always_comb rdata0 = read_port(raddr0);
  always_comb rdata1 = read_port(raddr1);
  always_comb rdata2 = read_port(raddr2);

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: commits valE/valM into the register file, keeps the
// sticky architectural status and counts retired instructions.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int NREG   = 15,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       W_stat_i,
  input  logic [63:0]      W_pc_i,
  input  logic [3:0]       W_icode_i,
  input  logic [63:0]      W_valE_i,
  input  logic [63:0]      W_valM_i,
  input  logic [3:0]       W_dstE_i,
  input  logic [3:0]       W_dstM_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  output logic [63:0]      d_rvalA_o,
  output logic [63:0]      d_rvalB_o,
  input  logic [3:0]       dbg_addr_i,
  output logic [63:0]      dbg_data_o,
  output logic [2:0]       stat_o,
  output logic             halted_o,
  output logic [63:0]      halt_pc_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  wb_state_e        state_q, state_n;
  stat_e            stat_in, stat_q;
  logic             commit, capture, running;
  logic [63:0]      halt_pc_q;
  logic [CNT_W-1:0] retired_cnt_q;

  always_comb stat_in = normalize_stat(W_stat_i);

  assign running = (state_q == WB_RUN);
  assign commit  = running && (stat_in == SAOK);
  assign capture = running && ((stat_in == SHLT) || (stat_in == SADR) || (stat_in == SINS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= WB_RUN;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (capture) state_n = WB_HALTED;
  end

  always_comb begin
    halted_o = (state_q == WB_HALTED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q    <= SAOK;
      halt_pc_q <= '0;
    end else if (capture) begin
      stat_q    <= stat_in;
      halt_pc_q <= W_pc_i;
    end
  end

  // A halt retires; an address or instruction fault does not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_cnt_q <= '0;
    end else if (commit || (capture && (stat_in == SHLT))) begin
      retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  // Trace hook: a halt status must come from the halt instruction itself.
  always_ff @(posedge clk_i) begin
    if (capture && (stat_in == SHLT)) assert (W_icode_i == IHALT);
  end

  assign stat_o        = stat_q;
  assign halt_pc_o     = halt_pc_q;
  assign retired_cnt_o = retired_cnt_q;

  // Port B carries valM and is given priority so popq %rsp loads memory data.
  regfile_2w3r #(
    .NREG  (NREG),
    .W     (64),
    .BYPASS(BYPASS)
  ) u_regs (
    .clk    (clk_i),
    .rst    (rst_i),
    .we_a   (commit && (W_dstE_i != RNONE)),
    .waddr_a(W_dstE_i),
    .wdata_a(W_valE_i),
    .we_b   (commit && (W_dstM_i != RNONE)),
    .waddr_b(W_dstM_i),
    .wdata_b(W_valM_i),
    .prio_b (1'b1),
    .raddr0 (d_srcA_i),
    .raddr1 (d_srcB_i),
    .raddr2 (dbg_addr_i),
    .rdata0 (d_rvalA_o),
    .rdata1 (d_rvalB_o),
    .rdata2 (dbg_data_o)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: one instance without and one with
// same-cycle read bypass, driven by shared W-stage and read-port inputs.
module tb_writeback_regfile;
  import y86_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [2:0]  W_stat_i = 3'd0;
  logic [63:0] W_pc_i = '0;
  logic [3:0]  W_icode_i = 4'h1;
  logic [63:0] W_valE_i = '0;
  logic [63:0] W_valM_i = '0;
  logic [3:0]  W_dstE_i = 4'hF;
  logic [3:0]  W_dstM_i = 4'hF;
  logic [3:0]  d_srcA_i = 4'hF;
  logic [3:0]  d_srcB_i = 4'hF;
  logic [3:0]  dbg_addr_i = 4'hF;

  logic [63:0] rvalA, rvalB, dbg_data, halt_pc, cnt;
  logic [2:0]  stat;
  logic        halted;
  logic [63:0] rvalA_b, rvalB_b, dbg_data_b, halt_pc_b, cnt_b;
  logic [2:0]  stat_b;
  logic        halted_b;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  writeback_regfile #(.NREG(15), .BYPASS(1'b0), .CNT_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .W_stat_i(W_stat_i), .W_pc_i(W_pc_i),
    .W_icode_i(W_icode_i), .W_valE_i(W_valE_i), .W_valM_i(W_valM_i),
    .W_dstE_i(W_dstE_i), .W_dstM_i(W_dstM_i), .d_srcA_i(d_srcA_i),
    .d_srcB_i(d_srcB_i), .d_rvalA_o(rvalA), .d_rvalB_o(rvalB),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data), .stat_o(stat),
    .halted_o(halted), .halt_pc_o(halt_pc), .retired_cnt_o(cnt)
  );

  writeback_regfile #(.NREG(15), .BYPASS(1'b1), .CNT_W(64)) dut_byp (
    .clk_i(clk_i), .rst_i(rst_i), .W_stat_i(W_stat_i), .W_pc_i(W_pc_i),
    .W_icode_i(W_icode_i), .W_valE_i(W_valE_i), .W_valM_i(W_valM_i),
    .W_dstE_i(W_dstE_i), .W_dstM_i(W_dstM_i), .d_srcA_i(d_srcA_i),
    .d_srcB_i(d_srcB_i), .d_rvalA_o(rvalA_b), .d_rvalB_o(rvalB_b),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_b), .stat_o(stat_b),
    .halted_o(halted_b), .halt_pc_o(halt_pc_b), .retired_cnt_o(cnt_b)
  );

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  dste;
    logic [63:0] vale;
    logic [3:0]  dstm;
    logic [63:0] valm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
    logic [3:0]  dbg;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [63:0] exp_dbg;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] st, input logic [63:0] pc,
                               input logic [3:0] icode, input logic [3:0] dste,
                               input logic [63:0] vale, input logic [3:0] dstm,
                               input logic [63:0] valm);
    @(negedge clk_i);
    W_stat_i  = st;
    W_pc_i    = pc;
    W_icode_i = icode;
    W_dstE_i  = dste;
    W_valE_i  = vale;
    W_dstM_i  = dstm;
    W_valM_i  = valm;
  endtask

  task automatic clockEdge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    applyStimulus(3'd0, 64'h0, INOP, RNONE, 64'h0, RNONE, 64'h0);
  endtask

  initial begin
    //           stat  dstE  valE        dstM   valM       srcA   srcB   dbg    expA        expB        expDbg     cnt
    vecs[0] = '{3'd1, RRAX, 64'h1234,  RNONE, 64'h0,     RRAX,  RNONE, RRAX,  64'h1234,  64'h0,     64'h1234, 64'd1};
    vecs[1] = '{3'd0, RRAX, 64'hDEAD,  RRAX,  64'hDEAD,  RRAX,  RRAX,  RNONE, 64'h1234,  64'h1234,  64'h0,    64'd1};
    vecs[2] = '{3'd1, RRSP, 64'h100,   RRSP,  64'h200,   RRSP,  RRAX,  RRBX,  64'h200,   64'h1234,  64'h0,    64'd2};
    vecs[3] = '{3'd1, RNONE, 64'h777,  RRBX,  64'h333,   RRBX,  RRSP,  RRSP,  64'h333,   64'h200,   64'h200,  64'd3};
    vecs[4] = '{3'd1, RRBP, 64'hAAAA,  RRSI,  64'hBBBB,  RRBP,  RRSI,  RRAX,  64'hAAAA,  64'hBBBB,  64'h1234, 64'd4};
    vecs[5] = '{3'd1, RR14, 64'hE1,    RNONE, 64'h0,     RR14,  RNONE, RR14,  64'hE1,    64'h0,     64'hE1,   64'd5};

    // Asynchronous reset with no clock edge in between.
    #2 rst_i = 1'b1;
    d_srcA_i = RRAX;
    #1;
    checkOutput("reset_rvalA", rvalA, 64'h0);
    checkOutput("reset_stat", {61'h0, stat}, 64'd1);
    checkOutput("reset_halted", {63'h0, halted}, 64'd0);
    checkOutput("reset_halt_pc", halt_pc, 64'h0);
    checkOutput("reset_cnt", cnt, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].stat, 64'h10 + 64'(i), IOPQ, vecs[i].dste,
                    vecs[i].vale, vecs[i].dstm, vecs[i].valm);
      d_srcA_i   = vecs[i].srca;
      d_srcB_i   = vecs[i].srcb;
      dbg_addr_i = vecs[i].dbg;
      clockEdge();
      checkOutput($sformatf("vec%0d_rvalA", i), rvalA, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d_rvalB", i), rvalB, vecs[i].exp_b);
      checkOutput($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      checkOutput($sformatf("vec%0d_cnt", i), cnt, vecs[i].exp_cnt);
      checkOutput($sformatf("vec%0d_byp_rvalA", i), rvalA_b, vecs[i].exp_a);
      checkOutput($sformatf("vec%0d_halted", i), {63'h0, halted}, 64'd0);
    end

    // Same-cycle read of a register being written: old value vs bypassed value.
    applyStimulus(3'd1, 64'h20, IIRMOVQ, RRDX, 64'h55, RNONE, 64'h0);
    d_srcB_i = RRDX;
    #1;
    checkOutput("nobyp_pre_rdx", rvalB, 64'h0);
    checkOutput("byp_pre_rdx", rvalB_b, 64'h55);
    clockEdge();
    checkOutput("nobyp_post_rdx", rvalB, 64'h55);
    checkOutput("byp_post_rdx", rvalB_b, 64'h55);

    applyStimulus(3'd1, 64'h28, IPOPQ, RRDX, 64'h66, RRDX, 64'h77);
    #1;
    checkOutput("nobyp_pre_prio", rvalB, 64'h55);
    checkOutput("byp_pre_prio", rvalB_b, 64'h77);
    clockEdge();
    checkOutput("post_prio", rvalB, 64'h77);

    applyStimulus(3'd0, 64'h30, IOPQ, RRDX, 64'h99, RRDX, 64'h99);
    #1;
    checkOutput("byp_bubble_gated", rvalB_b, 64'h77);
    clockEdge();
    checkOutput("bubble_no_write", rvalB, 64'h77);
    checkOutput("bubble_cnt", cnt, 64'd7);

    // Counter wrap from all-ones.
    idle();
    force dut.retired_cnt_q = {64{1'b1}};
    #1 release dut.retired_cnt_q;
    #1;
    checkOutput("cnt_preload", cnt, {64{1'b1}});
    applyStimulus(3'd1, 64'h38, INOP, RNONE, 64'h0, RNONE, 64'h0);
    clockEdge();
    checkOutput("cnt_wrap", cnt, 64'h0);
    checkOutput("byp_cnt_nowrap", cnt_b, 64'd8);

    // Address fault freezes state and does not retire.
    applyStimulus(3'd3, 64'h40, IMRMOVQ, RRCX, 64'h1111, RNONE, 64'h0);
    d_srcA_i = RRCX;
    clockEdge();
    checkOutput("sadr_rcx", rvalA, 64'h0);
    checkOutput("sadr_stat", {61'h0, stat}, 64'd3);
    checkOutput("sadr_halted", {63'h0, halted}, 64'd1);
    checkOutput("sadr_halt_pc", halt_pc, 64'h40);
    checkOutput("sadr_cnt", cnt, 64'h0);
    applyStimulus(3'd1, 64'h48, IIRMOVQ, RRCX, 64'h2222, RNONE, 64'h0);
    clockEdge();
    checkOutput("halted_no_write", rvalA, 64'h0);
    checkOutput("halted_cnt", cnt, 64'h0);
    applyStimulus(3'd2, 64'h50, IHALT, RNONE, 64'h0, RNONE, 64'h0);
    clockEdge();
    checkOutput("sticky_stat", {61'h0, stat}, 64'd3);
    checkOutput("sticky_halt_pc", halt_pc, 64'h40);

    // Reset clears the halted state without a clock edge.
    idle();
    d_srcA_i = RRAX;
    rst_i = 1'b1;
    #1;
    checkOutput("rst2_rax", rvalA, 64'h0);
    checkOutput("rst2_stat", {61'h0, stat}, 64'd1);
    checkOutput("rst2_halted", {63'h0, halted}, 64'd0);
    idle();
    rst_i = 1'b0;

    applyStimulus(3'd1, 64'h80, IIRMOVQ, RRAX, 64'h5, RNONE, 64'h0);
    clockEdge();
    checkOutput("post_rst_rax", rvalA, 64'h5);
    applyStimulus(3'd2, 64'h88, IHALT, RNONE, 64'h0, RNONE, 64'h0);
    clockEdge();
    checkOutput("shlt_stat", {61'h0, stat}, 64'd2);
    checkOutput("shlt_halt_pc", halt_pc, 64'h88);
    checkOutput("shlt_cnt", cnt, 64'd2);
    checkOutput("shlt_halted", {63'h0, halted}, 64'd1);

    // Mid-cycle reset: outputs return to reset values immediately.
    #3 rst_i = 1'b1;
    #1;
    checkOutput("midrst_stat", {61'h0, stat}, 64'd1);
    checkOutput("midrst_halted", {63'h0, halted}, 64'd0);
    checkOutput("midrst_halt_pc", halt_pc, 64'h0);
    checkOutput("midrst_cnt", cnt, 64'h0);
    checkOutput("midrst_rax", rvalA, 64'h0);

    // Reset held across a commit edge: reset wins.
    applyStimulus(3'd1, 64'h90, IIRMOVQ, RRAX, 64'h99, RNONE, 64'h0);
    clockEdge();
    idle();
    rst_i = 1'b0;
    #1;
    checkOutput("rst_commit_rax", rvalA, 64'h0);
    checkOutput("rst_commit_cnt", cnt, 64'h0);

    // Undefined status code 7 is captured as SINS.
    applyStimulus(3'd7, 64'hC0, IOPQ, RRAX, 64'hF00, RNONE, 64'h0);
    clockEdge();
    checkOutput("stat7_stat", {61'h0, stat}, 64'd4);
    checkOutput("stat7_halt_pc", halt_pc, 64'hC0);
    checkOutput("stat7_rax", rvalA, 64'h0);
    checkOutput("stat7_cnt", cnt, 64'h0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
